// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the MEM stage and a word-addressed data memory.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned halfword/word requests return rsp_err).
module lsu_mem_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               sgn_q, sgn_d;
  logic [1:0]         lane_q, lane_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               accept;
  logic               misalign;
  logic               unused_addr;

  // Lane extraction for loads; a word-size request returns the whole word.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[8*lane +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed lanes of the sampled word.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00:   r[8*lane +: 8] = wd[7:0];
      2'b01:   if (lane[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (req_size == 2'b01) ? req_addr[0] :
                    (req_size[1] ? (req_addr[1:0] != 2'b00) : 1'b0);
`else
  assign misalign = 1'b0;
`endif

  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign req_ready   = (state_q == IDLE) && rst_n;
  assign accept      = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d        = req_we;
          size_d      = req_size;
          sgn_d       = req_signed;
          lane_d      = req_addr[1:0];
          wdata_d     = req_wdata;
          mem_addr_d  = req_addr[ADDR_W+1:2];
          cnt_d       = '0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (misalign) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we && req_size[1]) begin
            state_d     = WR;
            mem_write_d = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = RD;
            mem_read_d = 1'b1;
          end
        end
      end
      RD: begin
        mem_read_d = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        // Last latency cycle: mem_rdata is valid and gets consumed at this edge.
        if (cnt_q == CNT_LAST) begin
          mem_read_d = 1'b0;
          cnt_d      = '0;
          if (we_q) begin
            state_d     = WR;
            mem_write_d = 1'b1;
            mem_wdata_d = store_merge(mem_rdata, wdata_q, size_q, lane_q);
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_extract(mem_rdata, size_q, lane_q, sgn_q);
          end
        end
      end
      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
    we_q    <= we_d;
    size_q  <= size_d;
    sgn_q   <= sgn_d;
    lane_q  <= lane_d;
    wdata_q <= wdata_d;
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: one instance with MEM_LAT=1 and one with MEM_LAT=3.
module tb_lsu_mem_ctrl;

  localparam int ADDR_W = 5;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wdata;
    int          addr;
  } exp_t;

  logic clk;
  logic rst_n;
  logic sel;
  logic req_valid, req_we, req_signed, rsp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a, rsp_err_a, mem_read_a, mem_write_a;
  logic [31:0] rsp_rdata_a, mem_wdata_a, mem_rdata_a;
  logic [ADDR_W-1:0] mem_addr_a;
  logic req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b, rsp_err_b, mem_read_b, mem_write_b;
  logic [31:0] rsp_rdata_b, mem_wdata_b, mem_rdata_b;
  logic [ADDR_W-1:0] mem_addr_b;

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];

  logic v_req_ready, v_rsp_valid, v_rsp_err, v_mem_read, v_mem_write;
  logic [31:0] v_rsp_rdata, v_mem_wdata;
  logic [ADDR_W-1:0] v_mem_addr;

  int n_checks;
  int n_errors;
  exp_t sb[$];

  assign req_valid_a = req_valid & ~sel;
  assign req_valid_b = req_valid & sel;
  assign rsp_ready_a = sel ? 1'b1 : rsp_ready;
  assign rsp_ready_b = sel ? rsp_ready : 1'b1;

  assign v_req_ready = sel ? req_ready_b : req_ready_a;
  assign v_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
  assign v_rsp_err   = sel ? rsp_err_b   : rsp_err_a;
  assign v_rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;
  assign v_mem_read  = sel ? mem_read_b  : mem_read_a;
  assign v_mem_write = sel ? mem_write_b : mem_write_a;
  assign v_mem_wdata = sel ? mem_wdata_b : mem_wdata_a;
  assign v_mem_addr  = sel ? mem_addr_b  : mem_addr_a;

  lsu_mem_ctrl #(.MEM_LAT(1), .ADDR_W(ADDR_W)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .mem_read(mem_read_a),
    .mem_write(mem_write_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a)
  );

  lsu_mem_ctrl #(.MEM_LAT(3), .ADDR_W(ADDR_W)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .mem_read(mem_read_b),
    .mem_write(mem_write_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b)
  );

  function automatic logic [31:0] mem_init(input int i);
    case (i)
      1:       return 32'hCAFEF00D;
      3:       return 32'h8899AABB;
      5:       return 32'h11223344;
      default: return 32'h0;
    endcase
  endfunction

  // Memory models: combinational read, write on the strobe edge, preloaded during reset.
  assign mem_rdata_a = mem_a[mem_addr_a];
  assign mem_rdata_b = mem_b[mem_addr_b];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem_a[i] <= mem_init(i);
        mem_b[i] <= mem_init(i);
      end
    end else begin
      if (mem_write_a) mem_a[mem_addr_a] <= mem_wdata_a;
      if (mem_write_b) mem_b[mem_addr_b] <= mem_wdata_b;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic er, input int lat,
                              input int nrd, input int nwr, input logic [31:0] wd, input int ad);
    exp_t e;
    e.rdata = rd; e.err = er; e.lat = lat; e.nrd = nrd; e.nwr = nwr; e.wdata = wd; e.addr = ad;
    return e;
  endfunction

  // Drive one request, observe strobes until the response, then pop the scoreboard and compare.
  task automatic txn(input string tag, input logic s, input logic we, input logic [1:0] sz,
                     input logic sg, input logic [31:0] a, input logic [31:0] wd,
                     input exp_t e, input int hold);
    exp_t x;
    int lat, nrd, nwr, nboth, nrdy;
    logic [31:0] wdat;
    logic [ADDR_W-1:0] maddr;
    bit done;
    @(negedge clk);
    sel = s; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    sb.push_back(e);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (v_req_ready) done = 1;
      else @(negedge clk);
    end
    if (!done) begin
      check_eq({tag, "_accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      void'(sb.pop_back());
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; nrd = 0; nwr = 0; nboth = 0; nrdy = 0; wdat = '0; maddr = '0; done = 0;
    while (!done && lat < 40) begin
      if (v_mem_read) begin nrd++; maddr = v_mem_addr; end
      if (v_mem_write) begin nwr++; wdat = v_mem_wdata; maddr = v_mem_addr; end
      if (v_mem_read && v_mem_write) nboth++;
      if (v_req_ready) nrdy++;
      if (v_rsp_valid) done = 1;
      else begin @(negedge clk); lat++; end
    end
    x = sb.pop_front();
    if (!done) begin
      check_eq({tag, "_rsp_timeout"}, 32'd0, 32'd1);
      return;
    end
    check_eq({tag, "_rdata"}, v_rsp_rdata, x.rdata);
    check_eq({tag, "_err"}, 32'(v_rsp_err), 32'(x.err));
    check_eq({tag, "_lat"}, 32'(lat), 32'(x.lat));
    check_eq({tag, "_nrd"}, 32'(nrd), 32'(x.nrd));
    check_eq({tag, "_nwr"}, 32'(nwr), 32'(x.nwr));
    check_eq({tag, "_both"}, 32'(nboth), 32'd0);
    check_eq({tag, "_busy_ready"}, 32'(nrdy), 32'd0);
    if (x.nwr > 0) check_eq({tag, "_wdata"}, wdat, x.wdata);
    if (x.nrd + x.nwr > 0) check_eq({tag, "_maddr"}, 32'(maddr), 32'(x.addr));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, 32'(v_rsp_valid), 32'd1);
      check_eq({tag, "_hold_rdata"}, v_rsp_rdata, x.rdata);
      check_eq({tag, "_hold_ready"}, 32'(v_req_ready), 32'd0);
      check_eq({tag, "_hold_strobe"}, 32'(v_mem_read | v_mem_write), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_rsp_drop"}, 32'(v_rsp_valid), 32'd0);
    check_eq({tag, "_ready_after"}, 32'(v_req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready_a), 32'd0);
    check_eq("rst_mem_read", 32'(mem_read_a), 32'd0);
    check_eq("rst_mem_write", 32'(mem_write_a), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr_a), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata_a, 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid_a | rsp_valid_b), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata_a, 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(req_ready_a), 32'd1);

    // MEM_LAT = 1 instance
    txn("ld_word",   1'b0, 1'b0, 2'b10, 1'b0, 32'h0000000C, 32'h0, mk(32'h8899AABB, 0, 2, 1, 0, 0, 3), 0);
    txn("ld_sbyte",  1'b0, 1'b0, 2'b00, 1'b1, 32'h0000000E, 32'h0, mk(32'hFFFFFF99, 0, 2, 1, 0, 0, 3), 0);
    txn("ld_uhalf",  1'b0, 1'b0, 2'b01, 1'b0, 32'h0000000C, 32'h0, mk(32'h0000AABB, 0, 2, 1, 0, 0, 3), 0);
    txn("ld_shalf",  1'b0, 1'b0, 2'b01, 1'b1, 32'h0000000E, 32'h0, mk(32'hFFFF8899, 0, 2, 1, 0, 0, 3), 0);
    txn("ld_ubyte",  1'b0, 1'b0, 2'b00, 1'b0, 32'h0000000F, 32'h0, mk(32'h00000088, 0, 2, 1, 0, 0, 3), 0);
    txn("ld_size3",  1'b0, 1'b0, 2'b11, 1'b1, 32'h0000000C, 32'h0, mk(32'h8899AABB, 0, 2, 1, 0, 0, 3), 0);
    txn("st_byte",   1'b0, 1'b1, 2'b00, 1'b0, 32'h00000015, 32'h000000EE, mk(32'h0, 0, 3, 1, 1, 32'h1122EE44, 5), 0);
    txn("ld_after_sb", 1'b0, 1'b0, 2'b10, 1'b0, 32'h00000014, 32'h0, mk(32'h1122EE44, 0, 2, 1, 0, 0, 5), 0);
    txn("st_half",   1'b0, 1'b1, 2'b01, 1'b0, 32'h00000016, 32'hFFFF5A5A, mk(32'h0, 0, 3, 1, 1, 32'h5A5AEE44, 5), 0);
    txn("st_word",   1'b0, 1'b1, 2'b10, 1'b0, 32'h00000020, 32'hDEADBEEF, mk(32'h0, 0, 2, 0, 1, 32'hDEADBEEF, 8), 0);
    txn("ld_wrap",   1'b0, 1'b0, 2'b10, 1'b0, 32'h800000A0, 32'h0, mk(32'hDEADBEEF, 0, 2, 1, 0, 0, 8), 0);
`ifdef LSU_MISALIGN_TRAP_EN
    txn("ld_misal",  1'b0, 1'b0, 2'b10, 1'b0, 32'h00000006, 32'h0, mk(32'h0, 1, 1, 0, 0, 0, 0), 0);
    txn("ld_misal_h", 1'b0, 1'b0, 2'b01, 1'b0, 32'h0000000D, 32'h0, mk(32'h0, 1, 1, 0, 0, 0, 0), 0);
`else
    txn("ld_misal",  1'b0, 1'b0, 2'b10, 1'b0, 32'h00000006, 32'h0, mk(32'hCAFEF00D, 0, 2, 1, 0, 0, 1), 0);
    txn("ld_misal_h", 1'b0, 1'b0, 2'b01, 1'b0, 32'h0000000D, 32'h0, mk(32'h0000AABB, 0, 2, 1, 0, 0, 3), 0);
`endif

    // MEM_LAT = 3 instance
    txn("l3_ld_hold", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000000C, 32'h0, mk(32'h8899AABB, 0, 4, 3, 0, 0, 3), 5);
    txn("l3_st_byte", 1'b1, 1'b1, 2'b00, 1'b0, 32'h00000015, 32'h00000077, mk(32'h0, 0, 5, 3, 1, 32'h11227744, 5), 0);
    txn("l3_ld_shalf", 1'b1, 1'b0, 2'b01, 1'b1, 32'h00000014, 32'h0, mk(32'h00007744, 0, 4, 3, 0, 0, 5), 0);

    // Reset during the write cycle of a word store
    @(negedge clk);
    sel = 1'b0; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h00000024;
    req_wdata = 32'h12345678; req_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rst_wr_pre", 32'(mem_write_a), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_wr_write", 32'(mem_write_a), 32'd0);
    check_eq("rst_wr_rsp", 32'(rsp_valid_a), 32'd0);
    check_eq("rst_wr_ready_in_rst", 32'(req_ready_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_wr_ready", 32'(req_ready_a), 32'd1);
    check_eq("rst_wr_rsp2", 32'(rsp_valid_a), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("rst_wr_rsp3", 32'(rsp_valid_a), 32'd0);

    txn("post_rst_ld", 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000000C, 32'h0, mk(32'h8899AABB, 0, 2, 1, 0, 0, 3), 0);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
